// File: rtl/loop_nest.sv
// loop_nest: two-level nested index generator with a valid/ready output stream.
//
// On an accepted start the inner and outer limits are latched. The block then
// emits the (cnt_o, cnt_i) pairs for a row-major walk over 0..lim_o x 0..lim_i,
// one pair per cycle while ready is high. A one-cycle done pulse follows the
// final beat.
//
// Optional feature: define LOOP_NEST_ABORT_EN to add the abort input, which
// cancels a running job without a done pulse.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   rst    - synchronous active-high reset
//   start  - job request, sampled only while idle
//   lim_i  - inner loop limit (inclusive)
//   lim_o  - outer loop limit (inclusive)
//   busy   - high while a job is running or completing
//   done   - one-cycle pulse when a job completes
//   valid  - an index pair is being presented
//   ready  - consumer accepts the pair; a beat is valid && ready
//   cnt_i  - inner index
//   cnt_o  - outer index
//   last_i - current pair ends an inner row
//   last_o - current pair is the final pair of the job
//   abort  - cancel the running job (LOOP_NEST_ABORT_EN only)
module loop_nest #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] lim_i,
    input  logic [DATA_W-1:0] lim_o,
    output logic              busy,
    output logic              done,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] cnt_i,
    output logic [DATA_W-1:0] cnt_o,
    output logic              last_i,
    output logic              last_o
`ifdef LOOP_NEST_ABORT_EN
    ,
    input  logic              abort
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] cnt_i_q, cnt_i_d;
    logic [DATA_W-1:0] cnt_o_q, cnt_o_d;
    logic [DATA_W-1:0] lim_i_q, lim_i_d;
    logic [DATA_W-1:0] lim_o_q, lim_o_d;
    logic              beat;

    assign valid  = (state_q == StRun);
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign cnt_i  = cnt_i_q;
    assign cnt_o  = cnt_o_q;
    assign last_i = valid && (cnt_i_q == lim_i_q);
    assign last_o = last_i && (cnt_o_q == lim_o_q);
    assign beat   = valid && ready;

    always_comb begin
        state_d = state_q;
        cnt_i_d = cnt_i_q;
        cnt_o_d = cnt_o_q;
        lim_i_d = lim_i_q;
        lim_o_d = lim_o_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    lim_i_d = lim_i;
                    lim_o_d = lim_o;
                    cnt_i_d = '0;
                    cnt_o_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
`ifdef LOOP_NEST_ABORT_EN
                // Abort wins over a beat in the same cycle.
                if (abort) begin
                    cnt_i_d = '0;
                    cnt_o_d = '0;
                    state_d = StIdle;
                end else
`endif
                if (beat) begin
                    if (last_o) begin
                        cnt_i_d = '0;
                        cnt_o_d = '0;
                        state_d = StDone;
                    end else if (last_i) begin
                        // Counters stop at their limit, so a full-range limit never wraps.
                        cnt_i_d = '0;
                        cnt_o_d = cnt_o_q + 1'b1;
                    end else begin
                        cnt_i_d = cnt_i_q + 1'b1;
                    end
                end
            end
            StDone: begin
                // start is deliberately not queued here.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_i_q <= '0;
            cnt_o_q <= '0;
            lim_i_q <= '0;
            lim_o_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_i_q <= cnt_i_d;
            cnt_o_q <= cnt_o_d;
            lim_i_q <= lim_i_d;
            lim_o_q <= lim_o_d;
        end
    end

endmodule

// File: doc/loop_nest.md
LOOP_NEST -- requirements
Module: loop_nest

Interface
REQ-001 DATA_W, 8, width of both limit inputs and both counter outputs.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  job request; sampled only in IDLE.
REQ-005 lim_i  input  DATA_W  inner loop limit; inner counter runs 0..lim_i inclusive.
REQ-006 lim_o  input  DATA_W  outer loop limit; outer counter runs 0..lim_o inclusive.
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 done  output  1  one-cycle pulse at job completion.
REQ-009 valid  output  1  current (cnt_o, cnt_i) index pair is presented.
REQ-010 ready  input  1  consumer accepts the index pair; a beat is valid && ready.
REQ-011 cnt_i  output  DATA_W  inner index.
REQ-012 cnt_o  output  DATA_W  outer index.
REQ-013 last_i  output  1  combinational, aligned with cnt_i: valid && cnt_i == lim_i.
REQ-014 last_o  output  1  combinational: last_i && cnt_o == lim_o.
REQ-015 abort  input  1  cancels the running job; present only with LOOP_NEST_ABORT_EN.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 IDLE with start=1: lim_i and lim_o latched into internal registers, both counters cleared, next state RUN.
REQ-018 The latched limits SHALL be used for the whole job; lim_i/lim_o changes during RUN have no effect.
REQ-019 valid SHALL be 1 exactly while in RUN; the first pair (0,0) appears the cycle after start is accepted.
REQ-020 In a beat where cnt_i != lim_i, cnt_i SHALL increment and cnt_o SHALL hold.
REQ-021 In a beat where cnt_i == lim_i, cnt_i SHALL clear to 0, and cnt_o SHALL increment when cnt_o != lim_o.
REQ-022 In a beat where last_o = 1, the next state SHALL be DONE and the counters SHALL clear.
REQ-023 With valid=1 and ready=0, cnt_i, cnt_o, last_i and last_o SHALL hold stable.
REQ-024 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-025 start SHALL be ignored in RUN and DONE; a start during DONE is not queued.
REQ-026 A job SHALL produce exactly (lim_i+1)*(lim_o+1) beats in row-major order; limits of 0 give one beat.
REQ-027 Counters SHALL never exceed their latched limit, so lim = 2^DATA_W-1 reaches the full range without overflow.
REQ-028 Throughput SHALL be one beat per cycle while ready=1.

Reset
REQ-029 While rst=1: state IDLE; cnt_i, cnt_o and the latched limits 0; valid, last_i, last_o, busy and done 0.
REQ-030 rst SHALL take precedence over start, a handshake and abort in the same cycle; asserting rst mid-job discards the job with no done pulse.

Configuration
REQ-031 With LOOP_NEST_ABORT_EN defined, the abort port SHALL exist.
REQ-032 With LOOP_NEST_ABORT_EN defined, abort=1 in RUN SHALL force IDLE on the next cycle with counters cleared and no done pulse; abort has priority over a simultaneous beat, and abort in IDLE or DONE has no effect.
REQ-033 Without LOOP_NEST_ABORT_EN, the abort port and logic SHALL be absent, and a job ends only via last_o or rst.

Verification
REQ-034 Basic sequence: lim_i=2, lim_o=1, start pulse, ready=1 -> pairs (0,0)(0,1)(0,2)(1,0)(1,1)(1,2) on consecutive cycles; last_i on the 3rd and 6th beats; last_o on the 6th; done the next cycle; busy low after that.
REQ-035 Backpressure: same job with ready toggling 1,0,0,1,... -> outputs stable while ready=0, same 6 pairs in order, no duplicates.
REQ-036 Single beat: lim_i=0, lim_o=0 -> one beat (0,0) with last_i=last_o=1, then done.
REQ-037 Limit and start changes during a job: DATA_W=2, lim_i=3, lim_o=3, start re-pulsed and limits changed mid-job -> 16 beats up to (3,3), no overflow, extra starts ignored.
REQ-038 Reset mid-job: rst asserted after beat 3 -> valid=0 and counters 0 next cycle, no done; a new start then begins at (0,0).
REQ-039 Abort (LOOP_NEST_ABORT_EN only): abort in the same cycle as beat 2 -> beat not counted, valid=0 next cycle, done never asserted.
